i2c_slave_stretch: RTL and testbench

I2C slave byte engine that stretches the clock as the responder side of the bus. It detects START/STOP, matches a 7-bit address, and receives or transmits data bytes. While local logic has not consumed a received byte or supplied a transmit byte, it holds SCL low. It sits between the open-drain pad buffers and a local register/data interface, opposite the master's stretch-detect logic.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_slave_stretch.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave_stretch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states and bus-level constants.
package i2c_pkg;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_STRETCH,
        ST_RX_ACK,
        ST_TX_STRETCH,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA pads and derives edge and START/STOP pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d1;
    logic                   scl_d2;
    logic                   sda_d1;
    logic                   sda_d2;

    // Idle bus is high, so reset the chain to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d1   <= 1'b1;
            scl_d2   <= 1'b1;
            sda_d1   <= 1'b1;
            sda_d2   <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d1   <= scl_sync[SYNC_STAGES-1];
            scl_d2   <= scl_d1;
            sda_d1   <= sda_sync[SYNC_STAGES-1];
            sda_d2   <= sda_d1;
        end
    end

    assign sda       = sda_d1;
    assign scl_rise  = scl_d1 & ~scl_d2;
    assign scl_fall  = ~scl_d1 & scl_d2;
    assign start_det = scl_d1 & scl_d2 & sda_d2 & ~sda_d1;
    assign stop_det  = scl_d1 & scl_d2 & ~sda_d2 & sda_d1;

endmodule

// File: rtl/i2c_slave_stretch.sv
// I2C slave byte engine that holds SCL low until the local side consumes or
// supplies each data byte.
module i2c_slave_stretch
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h48,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t                  state, state_nxt;
    logic [2:0]              bit_cnt, bit_cnt_nxt;
    logic [I2C_DATA_W-1:0]   shreg, shreg_nxt;
    logic                    byte_done, byte_done_nxt;
    logic                    ack_seen, ack_seen_nxt;
    logic                    tx_hold, tx_hold_nxt;
    logic [I2C_DATA_W-1:0]   rx_data_nxt;
    logic                    rx_valid_nxt;
    logic                    tx_req_nxt;
    logic                    scl_oe_nxt;
    logic                    sda_oe_nxt;
    logic                    rw_nxt;
    logic                    busy_nxt;
    logic                    addr_match;

    // General call (address 0) never matches, even if SLAVE_ADDR were 0.
    assign addr_match = (shreg[7:1] == SLAVE_ADDR) && (shreg[7:1] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            ack_seen  <= 1'b0;
            tx_hold   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            byte_done <= byte_done_nxt;
            ack_seen  <= ack_seen_nxt;
            tx_hold   <= tx_hold_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            scl_oe    <= scl_oe_nxt;
            sda_oe    <= sda_oe_nxt;
            rw        <= rw_nxt;
            busy      <= busy_nxt;
        end
    end

    // START/STOP abort whatever is in flight; otherwise advance on SCL edges.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        byte_done_nxt = byte_done;
        ack_seen_nxt  = ack_seen;
        tx_hold_nxt   = tx_hold;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = rx_valid;
        tx_req_nxt    = tx_req;
        scl_oe_nxt    = scl_oe;
        sda_oe_nxt    = sda_oe;
        rw_nxt        = rw;
        busy_nxt      = busy;

        if (start_det || stop_det) begin
            scl_oe_nxt    = 1'b0;
            sda_oe_nxt    = 1'b0;
            rx_valid_nxt  = 1'b0;
            tx_req_nxt    = 1'b0;
            tx_hold_nxt   = 1'b0;
            busy_nxt      = 1'b0;
            bit_cnt_nxt   = '0;
            byte_done_nxt = 1'b0;
            ack_seen_nxt  = 1'b0;
            state_nxt     = start_det ? ST_ADDR : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (addr_match) begin
                            sda_oe_nxt = ~I2C_ACK;
                            rw_nxt     = shreg[0];
                            busy_nxt   = 1'b1;
                            state_nxt  = ST_ADDR_ACK;
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        if (rw) begin
                            scl_oe_nxt = 1'b1;
                            tx_req_nxt = 1'b1;
                            state_nxt  = ST_TX_STRETCH;
                        end else begin
                            state_nxt = ST_RX_BYTE;
                        end
                    end
                end

                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        scl_oe_nxt    = 1'b1;
                        rx_data_nxt   = shreg;
                        rx_valid_nxt  = 1'b1;
                        state_nxt     = ST_RX_STRETCH;
                    end
                end

                ST_RX_STRETCH: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid_nxt = 1'b0;
                        sda_oe_nxt   = ~I2C_ACK;
                        scl_oe_nxt   = 1'b0;
                        state_nxt    = ST_RX_ACK;
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = ST_RX_BYTE;
                    end
                end

                // SCL stays held one extra clk after loading so SDA settles first.
                ST_TX_STRETCH: begin
                    if (tx_req && tx_valid) begin
                        shreg_nxt   = tx_data;
                        sda_oe_nxt  = ~tx_data[7];
                        tx_req_nxt  = 1'b0;
                        tx_hold_nxt = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_TX_BYTE;
                    end
                end

                ST_TX_BYTE: begin
                    if (tx_hold) begin
                        scl_oe_nxt  = 1'b0;
                        tx_hold_nxt = 1'b0;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nxt   = 1'b0;
                            bit_cnt_nxt  = '0;
                            ack_seen_nxt = 1'b0;
                            state_nxt    = ST_TX_ACK;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_oe_nxt  = ~shreg[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_NACK) state_nxt = ST_WAIT_STOP;
                        else                 ack_seen_nxt = 1'b1;
                    end else if (scl_fall && ack_seen) begin
                        ack_seen_nxt = 1'b0;
                        scl_oe_nxt   = 1'b1;
                        tx_req_nxt   = 1'b1;
                        state_nxt    = ST_TX_STRETCH;
                    end
                end

                ST_WAIT_STOP: begin
                    scl_oe_nxt = 1'b0;
                    sda_oe_nxt = 1'b0;
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_stretch.sv
// Directed bench: bus master model drives transfers; scoreboards check received
// and transmitted bytes while direct checks cover ACKs, stretching and reset.
module tb_i2c_slave_stretch;
    import i2c_pkg::*;

    localparam int Q     = 5;
    localparam int BOUND = 2000;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       scl_oe, sda_oe, rx_valid, tx_req, rw, busy;
    logic [7:0] rx_data;
    logic       scl_bus, sda_bus;

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_stretch #(
        .SLAVE_ADDR (7'h48),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl_bus),
        .sda_in  (sda_bus),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_req  (tx_req),
        .rw      (rw),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rx_delay = 0;
    int tx_delay = 1;
    int oe_cnt = 0;
    int last_oe_len = 0;
    int oe_rise_cyc = 0;
    int fall_cyc = 0;
    int byte_fall_cyc = 0;
    logic oe_prev = 1'b0;
    logic oe_seen = 1'b0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] rd_obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound of %0d clk expired", name, BOUND);
    endtask

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic waitSclHigh();
        int n = 0;
        while (scl_bus !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) timeoutFail("scl_release");
    endtask

    task automatic startCond();
        sda_m = 1'b1; scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic repStart();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; waitSclHigh(); quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic stopCond();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; waitSclHigh(); quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic writeBit(input logic b);
        sda_m = b; quarter();
        scl_m = 1'b1; waitSclHigh(); quarter();
        scl_m = 1'b0; fall_cyc = cyc; quarter();
    endtask

    task automatic readBit(output logic b);
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; waitSclHigh(); quarter();
        b = sda_bus;
        scl_m = 1'b0; quarter();
    endtask

    task automatic writeByte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(data[i]);
        byte_fall_cyc = fall_cyc;
        readBit(ack);
    endtask

    task automatic readByte(input logic ack_bit);
        logic [7:0] b;
        logic       v;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            readBit(v);
            b[i] = v;
        end
        rd_obs_q.push_back(b);
        writeBit(ack_bit);
    endtask

    task automatic applyStimulus(input string label);
        $display("[TB] %s", label);
        oe_seen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Consumer: accept each received byte rx_delay clk after it appears.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && !rx_ready) begin
                repeat (rx_delay) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        end
    end

    // Producer: answer tx_req with the next queued byte after tx_delay clk.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1 && !tx_valid && tx_src_q.size() > 0) begin
                repeat (tx_delay - 1) @(negedge clk);
                tx_data  = tx_src_q.pop_front();
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
    end

    // Receive scoreboard: compare at every rx handshake.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready) begin
            if (rx_exp_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else                      checkOutput("rx_byte", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
    end

    // Transmit scoreboard: compare whatever byte the master assembled.
    always @(negedge clk) begin
        if (rd_obs_q.size() > 0) begin
            logic [7:0] got;
            got = rd_obs_q.pop_front();
            if (tx_exp_q.size() == 0) checkOutput("tx_unexpected", 32'(got), 32'hFFFF_FFFF);
            else                      checkOutput("tx_byte", 32'(got), 32'(tx_exp_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (scl_oe === 1'b1) begin
            oe_cnt++;
        end else if (oe_cnt > 0) begin
            last_oe_len = oe_cnt;
            oe_cnt = 0;
        end
        if (scl_oe === 1'b1 && !oe_prev) oe_rise_cyc = cyc;
        oe_prev = (scl_oe === 1'b1);
        if (scl_oe === 1'b1 || sda_oe === 1'b1) oe_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ack;
        logic ack5;

        repeat (3) @(negedge clk);
        checkOutput("reset_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_tx_req", 32'(tx_req), 32'd0);
        checkOutput("reset_rw", 32'(rw), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        reset = 1'b0;

        applyStimulus("write 0x90 0xA5, consumer stalls 20 clk");
        rx_delay = 20;
        rx_exp_q.push_back(8'hA5);
        startCond();
        writeByte(8'h90, ack);
        checkOutput("t1_addr_ack", 32'(ack), 32'd0);
        checkOutput("t1_rw", 32'(rw), 32'd0);
        writeByte(8'hA5, ack);
        checkOutput("t1_data_ack", 32'(ack), 32'd0);
        checkOutput("t1_stretch_len", 32'(last_oe_len), 32'd21);
        checkOutput("t1_stretch_latency", 32'(oe_rise_cyc - byte_fall_cyc), 32'd4);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        stopCond();
        checkOutput("t1_busy_after_stop", 32'(busy), 32'd0);

        applyStimulus("read 0x91, tx_data 0x3C after 15 clk, master NACK");
        rx_delay = 0;
        tx_delay = 15;
        tx_src_q.push_back(8'h3C);
        tx_exp_q.push_back(8'h3C);
        startCond();
        writeByte(8'h91, ack);
        checkOutput("t2_addr_ack", 32'(ack), 32'd0);
        checkOutput("t2_rw", 32'(rw), 32'd1);
        readByte(1'b1);
        checkOutput("t2_stretch_len", 32'(last_oe_len), 32'd16);
        checkOutput("t2_state_wait_stop", 32'(dut.state), 32'(ST_WAIT_STOP));
        checkOutput("t2_busy", 32'(busy), 32'd1);
        stopCond();
        checkOutput("t2_state_idle", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("t2_busy_after_stop", 32'(busy), 32'd0);

        applyStimulus("address 0x49 is not ours");
        startCond();
        writeByte(8'h92, ack);
        checkOutput("t3_addr_nack", 32'(ack), 32'd1);
        checkOutput("t3_no_drive", 32'(oe_seen), 32'd0);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        stopCond();

        applyStimulus("repeated START after 4 data bits");
        rx_exp_q.push_back(8'h3E);
        startCond();
        writeByte(8'h90, ack);
        checkOutput("t4_addr_ack", 32'(ack), 32'd0);
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b0);
        repStart();
        checkOutput("t4_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        writeByte(8'h90, ack);
        checkOutput("t4_readdr_ack", 32'(ack), 32'd0);
        writeByte(8'h3E, ack);
        checkOutput("t4_data_ack", 32'(ack), 32'd0);
        stopCond();

        applyStimulus("reset during RX_STRETCH");
        rx_delay = 300;
        startCond();
        writeByte(8'h90, ack);
        checkOutput("t5_addr_ack", 32'(ack), 32'd0);
        fork
            writeByte(8'h5A, ack5);
            begin
                int n = 0;
                while (rx_valid !== 1'b1 && n < BOUND) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= BOUND) timeoutFail("t5_rx_valid");
                repeat (3) @(negedge clk);
                checkOutput("t5_state_stretch", 32'(dut.state), 32'(ST_RX_STRETCH));
                reset = 1'b1;
                @(negedge clk);
                checkOutput("t5_scl_oe", 32'(scl_oe), 32'd0);
                checkOutput("t5_sda_oe", 32'(sda_oe), 32'd0);
                checkOutput("t5_rx_valid", 32'(rx_valid), 32'd0);
                reset = 1'b0;
            end
        join
        checkOutput("t5_data_nack", 32'(ack5), 32'd1);
        stopCond();
        rx_delay = 0;
        rx_exp_q.push_back(8'h77);
        startCond();
        writeByte(8'h90, ack);
        checkOutput("t5b_addr_ack", 32'(ack), 32'd0);
        writeByte(8'h77, ack);
        checkOutput("t5b_data_ack", 32'(ack), 32'd0);
        stopCond();

        applyStimulus("two-byte read 0x11 0x22");
        tx_delay = 3;
        tx_src_q.push_back(8'h11);
        tx_src_q.push_back(8'h22);
        tx_exp_q.push_back(8'h11);
        tx_exp_q.push_back(8'h22);
        startCond();
        writeByte(8'h91, ack);
        checkOutput("t6_addr_ack", 32'(ack), 32'd0);
        readByte(1'b0);
        readByte(1'b1);
        checkOutput("t6_second_stretch_len", 32'(last_oe_len), 32'd4);
        stopCond();

        repeat (20) @(negedge clk);
        checkOutput("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        checkOutput("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
